// File: rtl/miss_fill_controller.sv
// Cache miss fill controller: serves I-/D-cache line misses as word bursts from memory.
// Define MISS_CWF_EN to fetch the missing word first, then wrap through the line.
module miss_fill_controller #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          imiss,
  input  logic                          dmiss,
  input  logic [ADDR_W-1:0]             iaddr,
  input  logic [ADDR_W-1:0]             daddr,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ack,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          fill_we,
  output logic                          fill_dsel,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [DATA_W-1:0]             fill_data,
  output logic                          ifill,
  output logic                          dfill,
  output logic                          busy
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam logic [OFF_W-1:0]  ONE_OFF   = OFF_W'(1);
  localparam logic [OFF_W-1:0]  LAST_CNT  = OFF_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                start_s;
  logic                sel_d_s;
  logic [ADDR_W-1:0]   miss_addr_s;
  logic [OFF_W-1:0]    start_off_s;

  logic [ADDR_W-1:0]   base_r;
  logic [OFF_W-1:0]    off_r;
  logic [OFF_W-1:0]    cnt_r;
  logic                dsel_r;
  logic                fill_we_r;
  logic                fill_dsel_r;
  logic [OFF_W-1:0]    fill_idx_r;
  logic [DATA_W-1:0]   fill_data_r;

  assign miss_addr_s = sel_d_s ? daddr : iaddr;

`ifdef MISS_CWF_EN
  assign start_off_s = miss_addr_s[OFF_W+1:2];
`else
  assign start_off_s = {OFF_W{1'b0}};
`endif

  // Next-state decode; dmiss has priority, HOLD ignores misses for one re-probe cycle.
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    sel_d_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (dmiss) begin
          state_s = FILL;
          start_s = 1'b1;
          sel_d_s = 1'b1;
        end else if (imiss) begin
          state_s = FILL;
          start_s = 1'b1;
          sel_d_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (mem_ack && (cnt_r == LAST_CNT)) begin
          state_s = DONE;
        end else begin
          state_s = FILL;
        end
      end
      DONE:    state_s = HOLD;
      HOLD:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Burst bookkeeping and one-cycle-delayed fill write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r      <= {ADDR_W{1'b0}};
      off_r       <= {OFF_W{1'b0}};
      cnt_r       <= {OFF_W{1'b0}};
      dsel_r      <= 1'b0;
      fill_we_r   <= 1'b0;
      fill_dsel_r <= 1'b0;
      fill_idx_r  <= {OFF_W{1'b0}};
      fill_data_r <= {DATA_W{1'b0}};
    end else begin
      fill_we_r <= 1'b0;
      if (start_s) begin
        base_r <= miss_addr_s & ~LINE_MASK;
        off_r  <= start_off_s;
        cnt_r  <= {OFF_W{1'b0}};
        dsel_r <= sel_d_s;
      end else if ((state_r == FILL) && mem_ack) begin
        off_r       <= off_r + ONE_OFF;
        cnt_r       <= cnt_r + ONE_OFF;
        fill_we_r   <= 1'b1;
        fill_dsel_r <= dsel_r;
        fill_idx_r  <= off_r;
        fill_data_r <= mem_rdata;
      end
    end
  end

  // All outputs decode only from registers, so reset clears them immediately.
  assign mem_req   = (state_r == FILL);
  assign mem_addr  = (state_r == FILL) ?
                     (base_r | {{(ADDR_W-OFF_W-2){1'b0}}, off_r, 2'b00}) : {ADDR_W{1'b0}};
  assign busy      = (state_r != IDLE);
  assign ifill     = (state_r == DONE) && !dsel_r;
  assign dfill     = (state_r == DONE) && dsel_r;
  assign fill_we   = fill_we_r;
  assign fill_dsel = fill_dsel_r;
  assign fill_idx  = fill_idx_r;
  assign fill_data = fill_data_r;

endmodule

// File: tb/tb_miss_fill_controller.sv
// Directed bench for miss_fill_controller (LINE_WORDS=4); expectations follow MISS_CWF_EN.
module tb_miss_fill_controller;

`ifdef MISS_CWF_EN
  localparam int CWF = 1;
`else
  localparam int CWF = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        imiss, dmiss;
  logic [31:0] iaddr, daddr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        fill_we, fill_dsel;
  logic [1:0]  fill_idx;
  logic [31:0] fill_data;
  logic        ifill, dfill, busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ifill_cnt = 0;
  int dfill_cnt = 0;

  miss_fill_controller #(.LINE_WORDS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imiss(imiss), .dmiss(dmiss), .iaddr(iaddr), .daddr(daddr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_dsel(fill_dsel), .fill_idx(fill_idx), .fill_data(fill_data),
    .ifill(ifill), .dfill(dfill), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (ifill) ifill_cnt++;
    if (dfill) dfill_cnt++;
    check("excl_fill", {31'b0, ifill & dfill}, 32'd0);
  endtask

  // Called at the first FILL cycle; walks the burst through DONE and HOLD back to IDLE.
  task automatic do_burst(input logic is_d, input logic [31:0] base, input int start,
                          input int gap, input int drop_after, output int nsteps);
    int acks, cyc, off, we_cnt;
    logic [31:0] word;
    acks = 0; cyc = 0; we_cnt = 0; nsteps = 0;
    while (acks < 4 && cyc < 64) begin
      off  = (start + acks) % 4;
      word = 32'hC0DE_0000 ^ (base + 32'(off * 4));
      check("req", {31'b0, mem_req}, 32'd1);
      check("addr", mem_addr, base + 32'(off * 4));
      mem_ack   = ((cyc % gap) == gap - 1);
      mem_rdata = word;
      step();
      nsteps++;
      cyc++;
      check("we", {31'b0, fill_we}, {31'b0, mem_ack});
      if (fill_we) we_cnt++;
      if (mem_ack) begin
        acks++;
        check("idx", {30'b0, fill_idx}, 32'(off));
        check("data", fill_data, word);
        check("dsel", {31'b0, fill_dsel}, {31'b0, is_d});
      end
      if (acks == drop_after) begin
        if (is_d) dmiss = 1'b0;
        else imiss = 1'b0;
      end
    end
    mem_ack = 1'b0;
    if (acks < 4) check("ack_timeout", 32'(acks), 32'd4);
    check("we_cnt", 32'(we_cnt), 32'd4);
    check("done_busy", {31'b0, busy}, 32'd1);
    check("done_req", {31'b0, mem_req}, 32'd0);
    check("done_ifill", {31'b0, ifill}, {31'b0, !is_d});
    check("done_dfill", {31'b0, dfill}, {31'b0, is_d});
    if (is_d) dmiss = 1'b0;
    else imiss = 1'b0;
    step();
    check("hold_busy", {31'b0, busy}, 32'd1);
    check("hold_req", {31'b0, mem_req}, 32'd0);
    check("hold_we", {31'b0, fill_we}, 32'd0);
    check("hold_pulse", {30'b0, ifill, dfill}, 32'd0);
    step();
    check("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n, ic, dc;
    rst_n = 1'b0; imiss = 1'b0; dmiss = 1'b0; iaddr = 32'h0; daddr = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #12;
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    step();

    // D miss at 0x1008, ack every cycle; miss cycle counts as cycle 1, dfill due in cycle 6.
    daddr = 32'h0000_1008; dmiss = 1'b1;
    check("A_idle", {31'b0, busy}, 32'd0);
    step();
    do_burst(1'b1, 32'h0000_1000, CWF ? 2 : 0, 1, 99, n);
    check("A_latency", 32'(n + 2), 32'd6);

    // Simultaneous misses: D first, I after the HOLD cycle.
    ic = ifill_cnt; dc = dfill_cnt;
    iaddr = 32'h0000_0400; daddr = 32'h0000_0800; imiss = 1'b1; dmiss = 1'b1;
    step();
    do_burst(1'b1, 32'h0000_0800, 0, 1, 99, n);
    check("B_no_ifill_yet", 32'(ifill_cnt - ic), 32'd0);
    step();
    do_burst(1'b0, 32'h0000_0400, 0, 1, 99, n);
    check("B_ifill", 32'(ifill_cnt - ic), 32'd1);
    check("B_dfill", 32'(dfill_cnt - dc), 32'd1);

    // Ack every third cycle; address must hold between acks.
    ic = ifill_cnt;
    iaddr = 32'h0000_2004; imiss = 1'b1;
    step();
    do_burst(1'b0, 32'h0000_2000, CWF ? 1 : 0, 3, 99, n);
    check("C_ifill", 32'(ifill_cnt - ic), 32'd1);

    // I miss withdrawn after two acks; burst still completes.
    ic = ifill_cnt;
    iaddr = 32'h0000_300C; imiss = 1'b1;
    step();
    do_burst(1'b0, 32'h0000_3000, CWF ? 3 : 0, 1, 2, n);
    check("D_ifill", 32'(ifill_cnt - ic), 32'd1);

    // Reset after the second ack; held miss restarts cleanly.
    ic = ifill_cnt; dc = dfill_cnt;
    daddr = 32'h0000_4008; dmiss = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    step();
    step();
    check("E_pre_we", {31'b0, fill_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("E_rst_req", {31'b0, mem_req}, 32'd0);
    check("E_rst_busy", {31'b0, busy}, 32'd0);
    check("E_rst_addr", mem_addr, 32'h0);
    check("E_rst_we", {31'b0, fill_we}, 32'd0);
    check("E_rst_dsel", {31'b0, fill_dsel}, 32'd0);
    check("E_rst_idx", {30'b0, fill_idx}, 32'd0);
    check("E_rst_data", fill_data, 32'h0);
    mem_ack = 1'b0;
    step();
    rst_n = 1'b1;
    check("E_idle", {31'b0, busy}, 32'd0);
    step();
    check("E_no_pulse", 32'(ifill_cnt - ic + dfill_cnt - dc), 32'd0);
    do_burst(1'b1, 32'h0000_4000, CWF ? 2 : 0, 1, 99, n);
    check("E_dfill", 32'(dfill_cnt - dc), 32'd1);
    check("E_ifill", 32'(ifill_cnt - ic), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/miss_fill_controller.md
MISS_FILL_CONTROLLER -- requirements
Module: miss_fill_controller

Interface
REQ-001 Parameter LINE_WORDS, default 4, words per cache line (power of two, 2..16).
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter DATA_W, default 32, word width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 imiss / dmiss  in  1 each  I-/D-cache miss, level, held by cache until served.
REQ-007 iaddr / daddr  in  ADDR_W each  missing byte address, valid while respective miss high.
REQ-008 mem_req  out  1  memory read request, held for whole burst.
REQ-009 mem_addr  out  ADDR_W  word-aligned address of the word currently requested.
REQ-010 mem_ack  in  1  memory returns mem_rdata for mem_addr this cycle.
REQ-011 mem_rdata  in  DATA_W  returned word.
REQ-012 fill_we  out  1  write one word into the selected cache.
REQ-013 fill_dsel  out  1  1 = D-cache target, 0 = I-cache target.
REQ-014 fill_idx  out  log2(LINE_WORDS)  word offset within line for fill_we.
REQ-015 fill_data  out  DATA_W  word for fill_we.
REQ-016 ifill / dfill  out  1 each  one-cycle pulse: line complete in I-/D-cache.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, FILL, DONE, HOLD.
REQ-019 IDLE: dmiss high -> FILL with D target; else imiss high -> FILL with I target; dmiss wins on simultaneous miss.
REQ-020 On IDLE->FILL the block SHALL latch line base (address with low log2(LINE_WORDS)+2 bits cleared), target, and start offset.
REQ-021 FILL: mem_req=1; mem_addr = base + 4*current offset; mem_addr SHALL stay stable until mem_ack.
REQ-022 Each mem_ack in FILL: offset advances by 1 modulo LINE_WORDS (wrap-around); word counter increments.
REQ-023 Cycle after each mem_ack: fill_we=1, fill_idx=acked offset, fill_data=captured mem_rdata, fill_dsel=latched target; otherwise fill_we=0.
REQ-024 On the LINE_WORDS-th ack: mem_req drops next cycle; state -> DONE.
REQ-025 DONE (exactly one cycle): last word's fill_we asserted, and dfill (D target) or ifill (I target) pulsed high; -> HOLD.
REQ-026 HOLD (exactly one cycle): misses ignored so the cache re-probes; -> IDLE.
REQ-027 Miss deasserting mid-FILL (e.g. flush on jump) SHALL NOT abort the burst; line completes and fill pulse still issues.
REQ-028 Miss arriving during FILL/DONE/HOLD for the other cache SHALL be served from IDLE afterward (pending dmiss+imiss -> D then I, each full latency).
REQ-029 Minimum miss-to-fill-pulse latency with mem_ack tied high: LINE_WORDS+2 cycles from miss sampled in IDLE.
REQ-030 ifill and dfill SHALL never be high in the same cycle.

Reset
REQ-031 rst_n low SHALL immediately force IDLE and all outputs to 0 (mem_req, mem_addr, fill_we, fill_dsel, fill_idx, fill_data, ifill, dfill, busy), including mid-burst.
REQ-032 After rst_n rises, no fill pulse SHALL issue for a burst interrupted by reset; held misses restart from IDLE.

Configuration
REQ-033 Macro MISS_CWF_EN defined: start offset = missing word offset (critical word first), wrapping through the line.
REQ-034 MISS_CWF_EN undefined: start offset = 0 always; words fetched 0..LINE_WORDS-1 in order; all other behaviour identical.

Verification
REQ-035 dmiss=1, daddr=0x0000_1008, mem_ack=1 always, CWF on -> mem_addr 0x1008,0x100C,0x1000,0x1004; fill_idx 2,3,0,1; dfill pulse at cycle 6.
REQ-036 Same stimulus, CWF off -> mem_addr 0x1000..0x100C ascending; fill_idx 0..3.
REQ-037 imiss (iaddr=0x400) and dmiss (daddr=0x800) rise same cycle -> D burst, dfill, HOLD, then I burst, ifill; never overlapping.
REQ-038 mem_ack every third cycle -> mem_addr held stable between acks; exactly 4 fill_we pulses; one ifill.
REQ-039 imiss dropped after 2 acks -> remaining 2 words still fetched; ifill still pulses.
REQ-040 rst_n low after 2nd ack -> mem_req=0 immediately; no ifill/dfill; with miss held, new burst restarts at start offset.
